uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one transmitter (2..8).
REQ-002 SHALL have parameter WORD_BYTES, default 4, bytes per requester word (1..4).
REQ-003 SHALL have port i_clock, input, 1, clock for all state.
REQ-004 SHALL have port i_reset, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port i_req, input, N_REQ, level request per requester.
REQ-006 SHALL have port i_word, input, N_REQ*WORD_BYTES*8, flattened words; requester k occupies slice k.
REQ-007 SHALL have port o_ack, output, N_REQ, one-hot one-cycle pulse when requester word is latched.
REQ-008 SHALL have port o_busy, output, 1, high whenever state is not IDLE.
REQ-009 SHALL have port o_tx_start, output, 1, one-cycle start strobe to the UART transmitter.
REQ-010 SHALL have port o_tx_data, output, 8, byte for the transmitter, stable from strobe to done.
REQ-011 SHALL have port i_tx_done_tick, input, 1, transmitter end-of-stop-bit pulse.

Function
REQ-012 SHALL implement states IDLE, SEND, WAIT, plus CHK when checksum is compiled in.
REQ-013 IDLE: if any i_req bit is high, SHALL grant round-robin from pointer, latch that word, pulse o_ack for the winner, clear byte index, go to SEND in the same cycle.
REQ-014 Round-robin pointer SHALL become winner+1 modulo N_REQ on each grant; lowest index wins when pointer is 0 and all requests are high.
REQ-015 SEND: SHALL assert o_tx_start for exactly one cycle with o_tx_data = latched byte[index], LSB byte first, then go to WAIT.
REQ-016 WAIT: on i_tx_done_tick, SHALL go to SEND with index+1 if index < WORD_BYTES-1, otherwise to IDLE (or CHK).
REQ-017 i_tx_done_tick SHALL be ignored in IDLE and SEND; i_req changes after grant SHALL NOT affect the frame in flight.
REQ-018 Minimum gap from done tick to next o_tx_start SHALL be one cycle, so the transmitter is back in IDLE.
REQ-019 o_tx_data SHALL hold its value in WAIT and IDLE (last byte sent).

Reset
REQ-020 On i_reset: state IDLE, pointer 0, index 0, latched word 0, checksum 0, o_ack 0, o_busy 0, o_tx_start 0, o_tx_data 0x00.
REQ-021 Reset mid-frame SHALL abort the frame without ack replay; the aborted requester is not re-acked until it is re-granted.

Configuration
REQ-022 Macro UART_TX_SCHEDULER_CHECKSUM_EN defined: after the last byte, CHK SHALL send one extra byte = XOR of all word bytes via SEND/WAIT timing, then IDLE.
REQ-023 Macro undefined: no CHK state, no checksum register; frame is exactly WORD_BYTES bytes.

Structure
REQ-024 Shared package SHALL hold state encodings (2-bit), byte width 8, and the default N_REQ/WORD_BYTES constants.
REQ-025 Round-robin grant logic SHALL be a separate sub-module rr_arbiter (inputs req, pointer; output one-hot grant); all else is in uart_tx_scheduler.

Verification
REQ-026 Single req[0], word 0x11223344, done tick 10 cycles after each start -> starts carry 0x44,0x33,0x22,0x11; ack[0] one pulse; o_busy low after the fourth done.
REQ-027 req = 4'b1111 held -> grant order 0,1,2,3,0; each ack one cycle; no overlapping frames.
REQ-028 Done tick injected in IDLE and SEND -> no state change, no extra o_tx_start.
REQ-029 i_reset asserted in WAIT after byte 2 -> next cycle all outputs at reset values, pointer 0.
REQ-030 CHECKSUM_EN defined, word 0x01020304 -> five starts 0x04,0x03,0x02,0x01,0x04; undefined -> four starts.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// uart_tx_scheduler_pkg: state encodings, byte width and default sizes shared by the scheduler.
package uart_tx_scheduler_pkg;
  localparam int BYTE_W = 8;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_WORD_BYTES = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2, CHK = 2'd3} state_t;
endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching upward from ptr and wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);
  int best, best_d, d;
  always_comb begin
    best = -1;
    best_d = N;
    d = 0;
    grant = '0;
    for (int i = 0; i < N; i++) begin
      d = (i + N - int'(ptr)) % N;
      if (req[i] && d < best_d) begin
        best_d = d;
        best = i;
      end
    end
    for (int i = 0; i < N; i++) grant[i] = (best == i);
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin multiplexes requester words onto one byte-wide UART transmitter.
// Define UART_TX_SCHEDULER_CHECKSUM_EN to append an XOR checksum byte to every frame.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WORD_BYTES = DEF_WORD_BYTES
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic [N_REQ-1:0]                i_req,
  input  logic [N_REQ*WORD_BYTES*8-1:0]   i_word,
  output logic [N_REQ-1:0]                o_ack,
  output logic                            o_busy,
  output logic                            o_tx_start,
  output logic [BYTE_W-1:0]               o_tx_data,
  input  logic                            i_tx_done_tick
);
  localparam int PW = $clog2(N_REQ);
  localparam int IW = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;
  localparam int WW = WORD_BYTES * BYTE_W;
  state_t state, state_n, wait_n;
  logic [N_REQ-1:0] grant;
  logic [PW-1:0] ptr, win;
  logic [IW-1:0] idx;
  logic [WW-1:0] word, sel_word;
  logic take, last;
  rr_arbiter #(.N(N_REQ)) u_arb (.req(i_req), .ptr(ptr), .grant(grant));
  always_comb begin
    win = '0;
    for (int i = 0; i < N_REQ; i++) if (grant[i]) win = PW'(i);
  end
  assign sel_word = i_word[int'(win)*WW +: WW];
  assign take = state == IDLE && |i_req;
  assign last = idx == IW'(WORD_BYTES - 1);
`ifdef UART_TX_SCHEDULER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum, csum_n;
  logic csum_sent;
  always_comb begin
    csum_n = '0;
    for (int b = 0; b < WORD_BYTES; b++) csum_n ^= sel_word[b*BYTE_W +: BYTE_W];
  end
`endif
  always_ff @(posedge i_clock) state <= i_reset ? IDLE : state_n;
  always_comb begin
`ifdef UART_TX_SCHEDULER_CHECKSUM_EN
    wait_n = csum_sent ? IDLE : last ? CHK : SEND;
`else
    wait_n = last ? IDLE : SEND;
`endif
    state_n = state == IDLE ? (|i_req ? SEND : IDLE) :
              state == SEND ? WAIT :
              state == WAIT ? (i_tx_done_tick ? wait_n : WAIT) : WAIT;
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ptr <= '0;
      idx <= '0;
      word <= '0;
      o_ack <= '0;
`ifdef UART_TX_SCHEDULER_CHECKSUM_EN
      csum <= '0;
      csum_sent <= 1'b0;
`endif
    end else begin
      o_ack <= take ? grant : '0;
      if (take) begin
        ptr <= win == PW'(N_REQ - 1) ? '0 : win + 1'b1;
        idx <= '0;
        word <= sel_word;
      end else if (state == WAIT && i_tx_done_tick && !last) begin
        idx <= idx + 1'b1;
      end
`ifdef UART_TX_SCHEDULER_CHECKSUM_EN
      if (take) begin
        csum <= csum_n;
        csum_sent <= 1'b0;
      end else if (state_n == CHK) begin
        csum_sent <= 1'b1;
      end
`endif
    end
  end
  always_comb begin
    o_busy = state != IDLE;
`ifdef UART_TX_SCHEDULER_CHECKSUM_EN
    o_tx_start = state == SEND || state == CHK;
    o_tx_data = csum_sent ? csum : word[8*idx +: 8];
`else
    o_tx_start = state == SEND;
    o_tx_data = word[8*idx +: 8];
`endif
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed tests of grant order, byte sequencing, done-tick filtering and reset abort.
module tb_uart_tx_scheduler;
  localparam int N = 4;
  localparam int WB = 4;
`ifdef UART_TX_SCHEDULER_CHECKSUM_EN
  localparam int FB = WB + 1;
`else
  localparam int FB = WB;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, done, busy, start;
  logic [N-1:0] req, ack;
  logic [N*WB*8-1:0] word;
  logic [7:0] data;
  int checks = 0, errors = 0, starts = 0;
  int acks[N];
  int order[$];

  uart_tx_scheduler #(.N_REQ(N), .WORD_BYTES(WB)) dut (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_word(word), .o_ack(ack),
    .o_busy(busy), .o_tx_start(start), .o_tx_data(data), .i_tx_done_tick(done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
    if (start) starts++;
    for (int k = 0; k < N; k++) if (ack[k]) begin
      acks[k]++;
      order.push_back(k);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; req = '0; done = 1'b0; word = '0;
    tick;
    tick;
    rst = 1'b0;
    starts = 0;
    for (int k = 0; k < N; k++) acks[k] = 0;
    order.delete();
  endtask

  task automatic serve(output logic [7:0] b);
    int n = 0;
    while (!start && n < 50) begin
      tick;
      n++;
    end
    checks++;
    if (!start) begin
      errors++;
      $display("FAIL serve_timeout: tx_start=%0b required 1", start);
    end
    b = data;
    repeat (9) tick;
    checks++;
    if (data !== b) begin
      errors++;
      $display("FAIL data_stable: tx_data=%h required %h", data, b);
    end
    done = 1'b1;
    tick;
    done = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '1; done = 1'b1; word = '1;
    tick;
    tick;
    checks++;
    if ({ack, busy, start, data} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b busy=%b start=%b data=%h required all zero", ack, busy, start, data);
    end
    rst = 1'b0; req = '0; done = 1'b0;
  endtask

  task automatic test_single;
    logic [7:0] got;
    logic [7:0] exp [5] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
    do_reset;
    word[31:0] = 32'h11223344;
    req = 4'b0001;
    tick;
    checks++;
    if (ack !== 4'b0001) begin
      errors++;
      $display("FAIL single_ack: ack=%b required 0001", ack);
    end
    req = '0;
    for (int b = 0; b < FB; b++) begin
      serve(got);
      checks++;
      if (got !== exp[b]) begin
        errors++;
        $display("FAIL single_byte%0d: data=%h required %h", b, got, exp[b]);
      end
    end
    checks++;
    if (busy !== 1'b0 || data !== exp[FB-1]) begin
      errors++;
      $display("FAIL single_end: busy=%b data=%h required 0 %h", busy, data, exp[FB-1]);
    end
    checks++;
    if (acks[0] !== 1 || starts !== FB) begin
      errors++;
      $display("FAIL single_counts: acks=%0d starts=%0d required 1 %0d", acks[0], starts, FB);
    end
  endtask

  task automatic test_round_robin;
    logic [7:0] got, exp;
    do_reset;
    for (int k = 0; k < N; k++)
      for (int b = 0; b < WB; b++) word[(k*WB+b)*8 +: 8] = 8'(8'h10*(k+1) + b);
    req = 4'b1111;
    for (int f = 0; f < 5; f++)
      for (int b = 0; b < FB; b++) begin
        if (f == 4 && b == FB - 1) req = '0;
        serve(got);
        exp = b < WB ? 8'(8'h10*((f%4)+1) + b) : 8'h00;
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL rr_f%0d_b%0d: data=%h required %h", f, b, got, exp);
        end
      end
    checks++;
    if (order.size() !== 5) begin
      errors++;
      $display("FAIL rr_ack_count: acks=%0d required 5", order.size());
    end else begin
      for (int f = 0; f < 5; f++) begin
        checks++;
        if (order[f] !== f % 4) begin
          errors++;
          $display("FAIL rr_order%0d: winner=%0d required %0d", f, order[f], f % 4);
        end
      end
    end
    checks++;
    if (starts !== 5*FB || busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_end: starts=%0d busy=%b required %0d 0", starts, busy, 5*FB);
    end
  endtask

  task automatic test_ignore_done;
    logic [7:0] got;
    logic [7:0] exp [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h04};
    do_reset;
    done = 1'b1;
    tick;
    done = 1'b0;
    checks++;
    if (busy !== 1'b0 || starts !== 0) begin
      errors++;
      $display("FAIL idle_done: busy=%b starts=%0d required 0 0", busy, starts);
    end
    word[2*32 +: 32] = 32'hD4C3B2A1;
    req = 4'b0100;
    tick;
    req = '0;
    done = 1'b1;
    tick;
    done = 1'b0;
    checks++;
    if (start !== 1'b0 || data !== 8'hA1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL send_done: start=%b data=%h busy=%b required 0 a1 1", start, data, busy);
    end
    repeat (3) tick;
    checks++;
    if (starts !== 1) begin
      errors++;
      $display("FAIL send_done_starts: starts=%0d required 1", starts);
    end
    done = 1'b1;
    tick;
    done = 1'b0;
    for (int b = 1; b < FB; b++) begin
      serve(got);
      checks++;
      if (got !== exp[b]) begin
        errors++;
        $display("FAIL ignore_byte%0d: data=%h required %h", b, got, exp[b]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_end: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] got;
    do_reset;
    word[1*32 +: 32] = 32'hDDCCBBAA;
    req = 4'b0010;
    tick;
    req = '0;
    serve(got);
    serve(got);
    tick;
    checks++;
    if (busy !== 1'b1 || data !== 8'hCC) begin
      errors++;
      $display("FAIL mid_pre: busy=%b data=%h required 1 cc", busy, data);
    end
    rst = 1'b1;
    tick;
    checks++;
    if ({ack, busy, start, data} !== 15'd0) begin
      errors++;
      $display("FAIL mid_reset: ack=%b busy=%b start=%b data=%h required all zero", ack, busy, start, data);
    end
    rst = 1'b0;
    repeat (3) tick;
    checks++;
    if (acks[1] !== 1 || starts !== 3) begin
      errors++;
      $display("FAIL mid_replay: acks=%0d starts=%0d required 1 3", acks[1], starts);
    end
    req = 4'b1010;
    tick;
    req = '0;
    checks++;
    if (ack !== 4'b0010) begin
      errors++;
      $display("FAIL mid_pointer: ack=%b required 0010", ack);
    end
  endtask

  task automatic test_checksum;
    logic [7:0] got;
    logic [7:0] exp [5] = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h04};
    do_reset;
    word[3*32 +: 32] = 32'h01020304;
    req = 4'b1000;
    tick;
    req = '0;
    for (int b = 0; b < FB; b++) begin
      serve(got);
      checks++;
      if (got !== exp[b]) begin
        errors++;
        $display("FAIL csum_byte%0d: data=%h required %h", b, got, exp[b]);
      end
    end
    repeat (20) tick;
    checks++;
    if (starts !== FB || busy !== 1'b0) begin
      errors++;
      $display("FAIL csum_count: starts=%0d busy=%b required %0d 0", starts, busy, FB);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; done = 1'b0; word = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_ignore_done;
    test_reset_mid_frame;
    test_checksum;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
